inst_rom_resp: RTL and testbench

INST_ROM_RESP -- requirements
Module: inst_rom_resp

---
 rtl/inst_rom_resp_pkg.sv | 29 ++
 rtl/inst_rom_resp_array.sv | 37 +++
 rtl/inst_rom_resp.sv | 164 ++++++++++++++++
 tb/tb_inst_rom_resp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_resp_pkg
// Shared definitions for the instruction ROM response block: the control state
// encoding, the NOP word returned for bad fetches, the legal fetch-latency
// range and the beat record carried down the fetch pipeline.
// -----------------------------------------------------------------------------
package inst_rom_resp_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // One in-flight fetch: live flag, error flag, its byte address and the
    // instruction word read for it.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } beat_t;

endpackage

// File: rtl/inst_rom_resp_array.sv
// -----------------------------------------------------------------------------
// inst_rom_array
// 2^AW x 32 instruction store with one synchronous write port and one
// asynchronous read port. The read result is registered by the caller into
// its first pipeline stage. The array has no reset so its contents survive
// both reset and ce dropping.
//
// Ports
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module inst_rom_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_resp.sv
// -----------------------------------------------------------------------------
// inst_rom_resp
// Instruction fetch responder. Words are loaded into the ROM while the PC stage
// holds ce low (LOAD). Once ce is high the block runs (RUN) and accepts one
// fetch per unstalled cycle into a LAT-deep pipeline; the ROM read is captured
// in the first stage and the last stage feeds the output register, so a beat
// accepted on one edge reaches the outputs LAT edges later. A flush kills all
// in-flight beats and holds off new requests for LAT cycles (DRAIN).
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active low
//   ce           in   fetch enable; low returns the block to LOAD
//   inst_address in   byte address of the requested instruction
//   stall        in   freeze pipeline and outputs
//   flush        in   kill in-flight beats (wins over stall)
//   load_en      in   ROM write strobe, honoured only in LOAD
//   load_addr    in   ROM word index for the write
//   load_data    in   ROM write data
//   inst         out  returned instruction word
//   inst_pc      out  byte address of inst
//   inst_valid   out  inst/inst_pc form a live beat
//   addr_err     out  live beat was misaligned or out of range
//   load_busy    out  load_en seen outside LOAD this cycle
// -----------------------------------------------------------------------------
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int AW  = 10,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [31:0]   inst_address,
    input  logic          stall,
    input  logic          flush,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic          inst_valid,
    output logic          addr_err,
    output logic          load_busy
);

    // An out-of-range LAT is pulled into the supported window.
    localparam int DEPTH = (LAT < LAT_MIN) ? LAT_MIN :
                           (LAT > LAT_MAX) ? LAT_MAX : LAT;

    state_t       state;
    state_t       state_next;
    logic [1:0]   drain_cnt;
    logic [1:0]   drain_cnt_next;

    logic         accept;
    logic         bad_addr;
    logic         rom_we;
    logic [31:0]  rom_rdata;
    beat_t        fetch_beat;
    beat_t        pipe [DEPTH];
    beat_t        out_beat;

    // Writes only land while loading; anywhere else they are flagged instead.
    assign rom_we    = load_en && (state == LOAD);
    assign load_busy = rst && load_en && (state != LOAD);

    // A request is taken only in RUN on a free-running, unredirected cycle.
    assign accept   = (state == RUN) && ce && !stall && !flush;
    assign bad_addr = (|inst_address[1:0]) || (|inst_address[31:AW+2]);

    inst_rom_array #(.AW(AW)) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (inst_address[AW+1:2]),
        .rdata (rom_rdata)
    );

    // Beat presented to the first stage; bad addresses carry a NOP.
    always_comb begin
        fetch_beat       = '0;
        fetch_beat.valid = accept;
        fetch_beat.err   = bad_addr;
        fetch_beat.pc    = inst_address;
        fetch_beat.data  = bad_addr ? NOP : rom_rdata;
    end

    // Next-state logic. DRAIN lasts LAT unstalled cycles; a repeat flush
    // restarts the count. Dropping ce always returns to LOAD.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (!ce) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    state_next = RUN;
                end
                RUN: begin
                    if (flush) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 2'd0;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        drain_cnt_next = 2'd0;
                    end else if (!stall) begin
                        if (drain_cnt == 2'(DEPTH - 1)) begin
                            state_next = RUN;
                        end else begin
                            drain_cnt_next = drain_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state_next = LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Fetch pipeline and output register. Flush or ce low only drop the
    // valid bits; stall freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
            out_beat <= '0;
        end else if (!ce || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i].valid <= 1'b0;
            end
            out_beat.valid <= 1'b0;
        end else if (!stall) begin
            pipe[0] <= fetch_beat;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
            out_beat <= pipe[DEPTH-1];
        end
    end

    assign inst       = out_beat.data;
    assign inst_pc    = out_beat.pc;
    assign inst_valid = out_beat.valid;
    assign addr_err   = out_beat.valid && out_beat.err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_resp
// Drives three copies of inst_rom_resp (LAT = 1, 2, 3) with one shared
// stimulus stream. A reference model of the control state and ROM contents
// pushes the expected beat for each accepted request onto a per-copy queue;
// the output monitor pops and compares whenever a copy presents a new beat.
// -----------------------------------------------------------------------------
module tb_inst_rom_resp;
    import inst_rom_resp_pkg::*;

    localparam int AW = 10;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          ce;
    logic          stall;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [31:0]   inst_address;

    logic [31:0]   inst_o   [3];
    logic [31:0]   pc_o     [3];
    logic          valid_o  [3];
    logic          err_o    [3];
    logic          busy_o   [3];

    exp_t          q [3][$];
    state_t        st [3];
    int            dcnt [3];
    logic [31:0]   mem [3][1024];
    exp_t          modelBeat;
    exp_t          monBeat;
    string         tag;

    int            cyc = 0;
    logic          advLast = 1'b1;
    logic          prevValid [3];
    logic [31:0]   prevInst [3];

    int            nChecks = 0;
    int            nFails = 0;

    // Three latency variants share every input.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        inst_rom_resp #(.AW(AW), .LAT(g + 1)) dut (
            .clk          (clk),
            .rst          (rst),
            .ce           (ce),
            .inst_address (inst_address),
            .stall        (stall),
            .flush        (flush),
            .load_en      (load_en),
            .load_addr    (load_addr),
            .load_data    (load_data),
            .inst         (inst_o[g]),
            .inst_pc      (pc_o[g]),
            .inst_valid   (valid_o[g]),
            .addr_err     (err_o[g]),
            .load_busy    (busy_o[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", name, observed, expected, $time);
        end
    endtask

    // One cycle of inputs, changed just after the rising edge.
    task automatic applyStimulus(input logic r, input logic c, input logic s, input logic f,
                                 input logic [31:0] a, input logic le,
                                 input logic [AW-1:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        rst          = r;
        ce           = c;
        stall        = s;
        flush        = f;
        inst_address = a;
        load_en      = le;
        load_addr    = la;
        load_data    = ld;
    endtask

    task automatic fetch(input logic [31:0] a, input logic s, input logic f);
        applyStimulus(1'b1, 1'b1, s, f, a, 1'b0, '0, 32'h0);
    endtask

    // Reference model: control state, ROM image and expected-beat queues.
    // A beat accepted on this edge is due at the monitor sample following
    // edge cyc+LAT; each stalled edge pushes that out by one.
    always @(posedge clk) begin
        advLast = !rst || !ce || flush || !stall;
        for (int i = 0; i < 3; i++) begin
            if (st[i] == LOAD && load_en) begin
                mem[i][load_addr] = load_data;
            end
            if (!rst || !ce) begin
                q[i].delete();
                st[i] = LOAD;
            end else if (flush) begin
                q[i].delete();
                dcnt[i] = 0;
                st[i] = (st[i] == LOAD) ? RUN : DRAIN;
            end else if (stall) begin
                for (int j = 0; j < q[i].size(); j++) begin
                    q[i][j].due = q[i][j].due + 1;
                end
                if (st[i] == LOAD) begin
                    st[i] = RUN;
                end
            end else begin
                case (st[i])
                    LOAD: st[i] = RUN;
                    RUN: begin
                        modelBeat.pc   = inst_address;
                        modelBeat.err  = (inst_address[1:0] != 2'b00) || (inst_address[31:AW+2] != '0);
                        modelBeat.data = modelBeat.err ? 32'h0 : mem[i][inst_address[AW+1:2]];
                        modelBeat.due  = cyc + i + 2;
                        q[i].push_back(modelBeat);
                    end
                    default: begin
                        if (dcnt[i] == i) st[i] = RUN;
                        else dcnt[i] = dcnt[i] + 1;
                    end
                endcase
            end
        end
        cyc = cyc + 1;
    end

    // Output monitor on the falling edge: new beats are scored, stalled
    // cycles must hold, and load_busy follows the model state.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                tag = $sformatf("L%0d", i + 1);
                if (advLast) begin
                    if (valid_o[i]) begin
                        if (q[i].size() == 0) begin
                            checkOutput({tag, " spurious valid"}, 32'(valid_o[i]), 32'd0);
                        end else begin
                            monBeat = q[i].pop_front();
                            checkOutput({tag, " inst"}, inst_o[i], monBeat.data);
                            checkOutput({tag, " inst_pc"}, pc_o[i], monBeat.pc);
                            checkOutput({tag, " addr_err"}, 32'(err_o[i]), 32'(monBeat.err));
                            checkOutput({tag, " latency"}, 32'(cyc), 32'(monBeat.due));
                        end
                    end else begin
                        checkOutput({tag, " idle addr_err"}, 32'(err_o[i]), 32'd0);
                        if (q[i].size() > 0 && q[i][0].due <= cyc) begin
                            checkOutput({tag, " missing beat"}, 32'(valid_o[i]), 32'd1);
                            void'(q[i].pop_front());
                        end
                    end
                end else begin
                    checkOutput({tag, " stall hold valid"}, 32'(valid_o[i]), 32'(prevValid[i]));
                    checkOutput({tag, " stall hold inst"}, inst_o[i], prevInst[i]);
                end
                checkOutput({tag, " load_busy"}, 32'(busy_o[i]),
                            32'(rst && load_en && (st[i] != LOAD)));
                prevValid[i] = valid_o[i];
                prevInst[i]  = inst_o[i];
            end
        end
    end

    initial begin
        rst          = 1'b0;
        ce           = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        load_en      = 1'b0;
        load_addr    = '0;
        load_data    = 32'h0;
        inst_address = 32'h0;

        $display("[TB] reset and ROM load");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd0, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset inst", inst_o[i], 32'h0);
            checkOutput("reset inst_pc", pc_o[i], 32'h0);
            checkOutput("reset inst_valid", 32'(valid_o[i]), 32'd0);
            checkOutput("reset addr_err", 32'(err_o[i]), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd1, 32'h2222_2222);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd2, 32'h3333_3333);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd3, 32'h4444_4444);

        $display("[TB] run back to back");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        fetch(32'h0, 1'b0, 1'b0);
        fetch(32'h4, 1'b0, 1'b0);
        fetch(32'h8, 1'b0, 1'b0);
        fetch(32'hC, 1'b0, 1'b0);
        repeat (3) fetch(32'hC, 1'b0, 1'b0);

        $display("[TB] stall");
        fetch(32'h4, 1'b0, 1'b0);
        fetch(32'h4, 1'b1, 1'b0);
        fetch(32'h4, 1'b1, 1'b0);
        repeat (5) fetch(32'h8, 1'b0, 1'b0);

        $display("[TB] flush");
        fetch(32'h0, 1'b0, 1'b0);
        fetch(32'h4, 1'b0, 1'b0);
        fetch(32'h8, 1'b0, 1'b1);
        repeat (6) fetch(32'h8, 1'b0, 1'b0);

        $display("[TB] flush with stall");
        fetch(32'h0, 1'b0, 1'b0);
        fetch(32'h4, 1'b1, 1'b1);
        repeat (5) fetch(32'h4, 1'b0, 1'b0);

        $display("[TB] address errors");
        fetch(32'h2, 1'b0, 1'b0);
        fetch(32'h0001_0000, 1'b0, 1'b0);
        repeat (4) fetch(32'h0, 1'b0, 1'b0);

        $display("[TB] load rejection");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 10'd0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 10'd1, 32'hDEAD_BEEF);
        repeat (4) fetch(32'h0, 1'b0, 1'b0);

        $display("[TB] ce drop");
        fetch(32'h4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, '0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, '0, 32'h0);
        repeat (5) fetch(32'h4, 1'b0, 1'b0);

        $display("[TB] reset mid-fetch");
        fetch(32'h4, 1'b0, 1'b0);
        fetch(32'h8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, '0, 32'h0);
        repeat (6) fetch(32'hC, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
